text_flush_scanner: RTL and testbench
=====================================

Name: text_flush_scanner

Overview:
- Raster sequencer that sits directly upstream of the character glyph LUT blocks and downstream-feeds the VGA adapter write port.
- On a start request, it walks flush_x/flush_y across a WIDTH x HEIGHT frame, one pixel per cycle.
- For each pixel it samples the combinational glyph response (colour/enable) and issues one registered plot write: glyph colour where enabled, background otherwise.
- Supports pause (backpressure), reports busy, and pulses done at frame end.

Parameters:
- WIDTH, 160, pixels per row; legal range 1..256.
- HEIGHT, 120, rows per frame; legal range 1..256.
- BG_COLOUR, 6'b000000, colour written where glyph_enable=0.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request a frame scan; sampled only in IDLE.
- pause  in  1  when 1 during SCAN: hold counters, deassert plot.
- flush_x  out  8  current scan column, driven to the glyph blocks.
- flush_y  out  8  current scan row, driven to the glyph blocks.
- glyph_colour  in  6  combinational glyph colour for (flush_x, flush_y).
- glyph_enable  in  1  combinational glyph hit for (flush_x, flush_y).
- vga_x  out  8  registered write column.
- vga_y  out  8  registered write row.
- vga_colour  out  6  registered write colour.
- vga_plot  out  1  registered write strobe; one pixel per high cycle.
- busy  out  1  1 in SCAN and DONE states.
- done  out  1  one-cycle pulse after the last pixel is written.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clock, resetn).
- Reset (any time, including mid-scan): state=IDLE; flush_x=flush_y=0; vga_x=vga_y=0; vga_colour=0; vga_plot=0; busy=0; done=0. No done pulse is produced for an aborted frame.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 at edge k -> SCAN, with flush_x=flush_y=0.
  - Otherwise stay in IDLE.
  - vga_plot=0 and the counters hold.
- SCAN, pause=0, each edge:
  - vga_x<=flush_x, vga_y<=flush_y, vga_plot<=1.
  - vga_colour<=glyph_enable ? glyph_colour : BG_COLOUR.
  - Advance counters: flush_x+1; at flush_x=WIDTH-1, wrap flush_x to 0 and increment flush_y.
- SCAN, pause=1:
  - vga_plot<=0.
  - Counters and vga_x/vga_y/vga_colour hold.
  - The pixel at the current coords is written on the first un-paused edge. No pixel is skipped or duplicated.
- SCAN, last pixel:
  - The edge that writes (WIDTH-1, HEIGHT-1) with pause=0 -> DONE.
  - flush_x/flush_y return to 0 on that edge.
- DONE (exactly one cycle):
  - Next edge: vga_plot<=0, done<=1 -> IDLE.
  - done clears on the following edge.
  - pause is ignored in DONE.
- Latency:
  - First vga_plot is high in the cycle after edge k+1.
  - With no pause, vga_plot is high for exactly WIDTH*HEIGHT consecutive cycles.
  - done is high in the cycle after edge k+WIDTH*HEIGHT+1.
- start during SCAN or DONE is ignored; it is not queued.
- start held high continuously: a new frame begins on the edge after done asserts.
- Edge cases:
  - WIDTH=1: every pixel is a row wrap.
  - WIDTH=HEIGHT=1: a single plot, then DONE.
- Arithmetic: counters are 8-bit; comparisons are against WIDTH-1 and HEIGHT-1 only. Values never exceed the bounds, so no modulo-256 wrap is relied on.
- The glyph path is combinational between flush_* and glyph_*. Only one glyph source is expected to assert enable for a given pixel; any OR-ing of multiple sources is done outside this block.

Test Plan:
- Reset, then WIDTH=4, HEIGHT=3, glyph_enable=0, pulse start -> 12 consecutive plots, order (0,0),(1,0),(2,0),(3,0),(0,1)...(3,2), all colour 0; done high 1 cycle after last plot; busy low after.
- WIDTH=4, HEIGHT=3, glyph_enable=1 only at (2,1) with glyph_colour=6'b111111 -> exactly that write has colour 111111; all others BG_COLOUR.
- Same frame, pause=1 for 3 cycles while flush=(1,1) -> plot low 3 cycles; the next write is (1,1); total plots still 12; done delayed by 3 cycles.
- Assert resetn=0 mid-scan at flush=(3,0) -> all outputs 0 immediately (asynchronous); no done; a later start rescans from (0,0).
- start held high through the whole frame -> no restart before done; second frame's first plot is (0,0), two cycles after the done cycle.
- WIDTH=1, HEIGHT=1 -> single plot at (0,0), done the cycle after.

Source files
------------

// File: rtl/text_flush_scanner.sv
// Raster sequencer: walks flush_x/flush_y over a WIDTH x HEIGHT frame and turns
// each combinational glyph response into one registered VGA plot write.
module text_flush_scanner #(
  parameter int         WIDTH     = 160,
  parameter int         HEIGHT    = 120,
  parameter logic [5:0] BG_COLOUR = 6'b000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] flush_x,
  output logic [7:0] flush_y,
  input  logic [5:0] glyph_colour,
  input  logic       glyph_enable,
  output logic [7:0] vga_x,
  output logic [7:0] vga_y,
  output logic [5:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

  state_t     state_r;
  logic       row_end_s;
  logic       frame_end_s;
  logic [5:0] pixel_colour_s;

  // Scan position decode and colour selection for the pixel under the counters
  always_comb begin
    row_end_s   = (flush_x == X_LAST);
    frame_end_s = row_end_s && (flush_y == Y_LAST);
    if (glyph_enable) begin
      pixel_colour_s = glyph_colour;
    end else begin
      pixel_colour_s = BG_COLOUR;
    end
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r    <= S_IDLE;
      flush_x    <= 8'd0;
      flush_y    <= 8'd0;
      vga_x      <= 8'd0;
      vga_y      <= 8'd0;
      vga_colour <= 6'd0;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          vga_plot <= 1'b0;
          done     <= 1'b0;
          if (start) begin
            state_r <= S_SCAN;
            busy    <= 1'b1;
            flush_x <= 8'd0;
            flush_y <= 8'd0;
          end else begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        S_SCAN: begin
          done <= 1'b0;
          busy <= 1'b1;
          // A paused edge holds everything so the same pixel is written once released
          if (pause) begin
            vga_plot <= 1'b0;
          end else begin
            vga_x      <= flush_x;
            vga_y      <= flush_y;
            vga_colour <= pixel_colour_s;
            vga_plot   <= 1'b1;
            if (frame_end_s) begin
              flush_x <= 8'd0;
              flush_y <= 8'd0;
              state_r <= S_DONE;
            end else if (row_end_s) begin
              flush_x <= 8'd0;
              flush_y <= flush_y + 8'd1;
            end else begin
              flush_x <= flush_x + 8'd1;
            end
          end
        end
        S_DONE: begin
          vga_plot <= 1'b0;
          done     <= 1'b1;
          busy     <= 1'b0;
          state_r  <= S_IDLE;
        end
        default: begin
          state_r  <= S_IDLE;
          vga_plot <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_flush_scanner.sv
// Randomized self-checking bench: a 4x3 scanner checked against a raster-order
// write list computed from glyph maps, plus a 1x1 scanner with a non-zero background.
module tb_text_flush_scanner;

  logic       clock = 1'b0;
  logic       resetn, start, pause;
  logic [7:0] flush_x, flush_y, vga_x, vga_y;
  logic [5:0] glyph_colour, vga_colour;
  logic       glyph_enable, vga_plot, busy, done;

  logic       start1, pause1;
  logic [7:0] flush_x1, flush_y1, vga_x1, vga_y1;
  logic [5:0] glyph_colour1, vga_colour1;
  logic       glyph_enable1, vga_plot1, busy1, done1;

  logic [5:0] col_map [12];
  logic       en_map  [12];

  int tests_run = 0;
  int tests_failed = 0;

  int obs_x[$], obs_y[$], obs_c[$], obs_cyc[$];
  int exp_x[$], exp_y[$], exp_c[$];
  int done_cyc, pcount, pattern_err;
  bit timed_out;

  text_flush_scanner #(.WIDTH(4), .HEIGHT(3), .BG_COLOUR(6'b000000)) dut (
    .clock(clock), .resetn(resetn), .start(start), .pause(pause),
    .flush_x(flush_x), .flush_y(flush_y),
    .glyph_colour(glyph_colour), .glyph_enable(glyph_enable),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .done(done)
  );

  text_flush_scanner #(.WIDTH(1), .HEIGHT(1), .BG_COLOUR(6'b101010)) dut1 (
    .clock(clock), .resetn(resetn), .start(start1), .pause(pause1),
    .flush_x(flush_x1), .flush_y(flush_y1),
    .glyph_colour(glyph_colour1), .glyph_enable(glyph_enable1),
    .vga_x(vga_x1), .vga_y(vga_y1), .vga_colour(vga_colour1), .vga_plot(vga_plot1),
    .busy(busy1), .done(done1)
  );

  always #5 clock = ~clock;

  // Glyph source: lookup tables addressed by the scan coordinates
  always_comb begin
    int idx;
    idx = int'(flush_y) * 4 + int'(flush_x);
    glyph_colour = 6'd0;
    glyph_enable = 1'b0;
    if (idx < 12) begin
      glyph_colour = col_map[idx];
      glyph_enable = en_map[idx];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: every pixel once, raster order, glyph colour where enabled else background
  function automatic void build_expected();
    exp_x.delete(); exp_y.delete(); exp_c.delete();
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) begin
        exp_x.push_back(x);
        exp_y.push_back(y);
        exp_c.push_back(en_map[y*4+x] ? int'(col_map[y*4+x]) : 0);
      end
  endfunction

  function automatic void randomize_maps();
    for (int i = 0; i < 12; i++) begin
      col_map[i] = 6'($urandom_range(0, 63));
      en_map[i]  = 1'($urandom_range(0, 1));
    end
  endfunction

  // Starts a frame on dut and records every write until done (or a cycle budget runs out).
  // mode: 0 no pause, 1 random pause, 2 pause three cycles while flush=(1,1)
  task automatic collect(input bit hold, input int mode);
    int remaining = 12;
    int paused_here = 0;
    int cyc = 0;
    bit exp_plot;
    obs_x.delete(); obs_y.delete(); obs_c.delete(); obs_cyc.delete();
    done_cyc = -1; pcount = 0; pattern_err = 0; timed_out = 0;
    start = 1'b1;
    @(posedge clock); #1;
    if (!hold) start = 1'b0;
    forever begin
      case (mode)
        1: pause = ($urandom_range(0, 3) == 0);
        2: pause = (flush_x == 8'd1 && flush_y == 8'd1 && paused_here < 3);
        default: pause = 1'b0;
      endcase
      if (mode == 2 && pause) paused_here++;
      exp_plot = (remaining > 0) && !pause;
      if (remaining > 0) begin
        if (pause) pcount++;
        else remaining--;
      end
      @(posedge clock); #1;
      cyc++;
      if (vga_plot !== exp_plot) pattern_err++;
      if (vga_plot === 1'b1) begin
        obs_x.push_back(int'(vga_x));
        obs_y.push_back(int'(vga_y));
        obs_c.push_back(int'(vga_colour));
        obs_cyc.push_back(cyc);
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (cyc > 400) begin
        timed_out = 1;
        break;
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; pause = 1'b0; start1 = 1'b0; pause1 = 1'b0;
    glyph_colour1 = 6'd0; glyph_enable1 = 1'b0;
    for (int i = 0; i < 12; i++) begin col_map[i] = 6'd0; en_map[i] = 1'b0; end
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if ({flush_x, flush_y, vga_x, vga_y, vga_colour, vga_plot, busy, done} !== 45'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %h, want 0", {flush_x, flush_y, vga_x, vga_y, vga_colour, vga_plot, busy, done});
    end
    tests_run++;
    if ({vga_x1, vga_y1, vga_colour1, vga_plot1, busy1, done1} !== 29'd0) begin
      tests_failed++;
      $display("FAIL reset_state_1x1: got %h, want 0", {vga_x1, vga_y1, vga_colour1, vga_plot1, busy1, done1});
    end
    resetn = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    tests_run++;
    if ({vga_plot, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL idle_no_start: plot/busy/done=%b, want 000", {vga_plot, busy, done});
    end
  endtask

  task automatic test_plain_frame();
    int errs = 0;
    for (int i = 0; i < 12; i++) begin col_map[i] = 6'($urandom_range(1, 63)); en_map[i] = 1'b0; end
    build_expected();
    collect(1'b0, 0);
    tests_run++;
    if (timed_out || obs_x.size() != 12) begin
      tests_failed++;
      $display("FAIL plain_count: got %0d writes (timeout=%0d), want 12", obs_x.size(), timed_out);
    end
    tests_run++;
    for (int i = 0; i < 12 && i < obs_x.size(); i++)
      if (obs_x[i] != exp_x[i] || obs_y[i] != exp_y[i] || obs_c[i] != exp_c[i]) begin
        if (errs == 0)
          $display("FAIL plain_pixel: write %0d got (%0d,%0d,%0d), want (%0d,%0d,%0d)",
                   i, obs_x[i], obs_y[i], obs_c[i], exp_x[i], exp_y[i], exp_c[i]);
        errs++;
      end
    if (errs != 0) tests_failed++;
    tests_run++;
    if (obs_cyc.size() != 12 || obs_cyc[0] != 1 || obs_cyc[11] != 12 || pattern_err != 0) begin
      tests_failed++;
      $display("FAIL plain_timing: plot pattern errors %0d, want 0 with plots in cycles 1..12", pattern_err);
    end
    tests_run++;
    if (done_cyc != 13) begin
      tests_failed++;
      $display("FAIL plain_done: done at cycle %0d, want 13", done_cyc);
    end
    tests_run++;
    if (busy !== 1'b0 || flush_x !== 8'd0 || flush_y !== 8'd0) begin
      tests_failed++;
      $display("FAIL plain_after: busy=%b flush=(%0d,%0d), want 0 (0,0)", busy, flush_x, flush_y);
    end
    @(posedge clock); #1;
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_pulse: done=%b one cycle later, want 0", done);
    end
  endtask

  task automatic test_glyph();
    for (int iter = 0; iter < 4; iter++) begin
      int errs = 0;
      if (iter == 0) begin
        for (int i = 0; i < 12; i++) begin col_map[i] = 6'($urandom_range(0, 63)); en_map[i] = 1'b0; end
        en_map[6] = 1'b1;
        col_map[6] = 6'b111111;
      end else begin
        randomize_maps();
      end
      build_expected();
      collect(1'b0, iter == 0 ? 0 : 1);
      tests_run++;
      for (int i = 0; i < 12; i++)
        if (i >= obs_x.size() || obs_x[i] != exp_x[i] || obs_y[i] != exp_y[i] || obs_c[i] != exp_c[i]) begin
          if (errs == 0)
            $display("FAIL glyph_pixel[%0d]: write %0d got (%0d,%0d,%0d), want (%0d,%0d,%0d)", iter,
                     i, obs_x[i], obs_y[i], obs_c[i], exp_x[i], exp_y[i], exp_c[i]);
          errs++;
        end
      if (errs != 0 || obs_x.size() != 12 || timed_out) tests_failed++;
      tests_run++;
      if (pattern_err != 0 || done_cyc != 13 + pcount) begin
        tests_failed++;
        $display("FAIL glyph_timing[%0d]: pattern errors %0d done %0d, want 0 and %0d", iter, pattern_err, done_cyc, 13 + pcount);
      end
    end
  endtask

  task automatic test_pause();
    int errs = 0;
    randomize_maps();
    build_expected();
    collect(1'b0, 2);
    tests_run++;
    for (int i = 0; i < 12; i++)
      if (i >= obs_x.size() || obs_x[i] != exp_x[i] || obs_y[i] != exp_y[i] || obs_c[i] != exp_c[i]) errs++;
    if (errs != 0 || obs_x.size() != 12) begin
      tests_failed++;
      $display("FAIL pause_pixels: %0d bad of %0d writes, want 0 bad of 12", errs, obs_x.size());
    end
    tests_run++;
    if (obs_cyc.size() != 12 || obs_cyc[4] != 5 || obs_cyc[5] != 9 || pattern_err != 0) begin
      tests_failed++;
      $display("FAIL pause_gap: write (1,1) at cycle %0d pattern errors %0d, want 9 and 0",
               obs_cyc.size() > 5 ? obs_cyc[5] : -1, pattern_err);
    end
    tests_run++;
    if (done_cyc != 16) begin
      tests_failed++;
      $display("FAIL pause_done: done at cycle %0d, want 16", done_cyc);
    end
  endtask

  task automatic test_reset_mid_scan();
    int seen = 0;
    int waited = 0;
    randomize_maps();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    while (!(flush_x == 8'd3 && flush_y == 8'd0) && waited < 20) begin
      @(posedge clock); #1;
      waited++;
    end
    tests_run++;
    if (waited >= 20) begin
      tests_failed++;
      $display("FAIL midscan_reach: flush=(%0d,%0d), want (3,0)", flush_x, flush_y);
    end
    #2 resetn = 1'b0;
    #1;
    tests_run++;
    if ({flush_x, flush_y, vga_x, vga_y, vga_colour, vga_plot, busy, done} !== 45'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got %h, want 0", {flush_x, flush_y, vga_x, vga_y, vga_colour, vga_plot, busy, done});
    end
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    repeat (20) begin
      @(posedge clock); #1;
      if (done === 1'b1 || vga_plot === 1'b1) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL aborted_frame: %0d cycles with done/plot, want 0", seen);
    end
    build_expected();
    collect(1'b0, 0);
    tests_run++;
    if (obs_x.size() != 12 || obs_x[0] != 0 || obs_y[0] != 0 || done_cyc != 13) begin
      tests_failed++;
      $display("FAIL rescan: %0d writes first (%0d,%0d) done %0d, want 12 (0,0) 13",
               obs_x.size(), obs_x.size() > 0 ? obs_x[0] : -1, obs_y.size() > 0 ? obs_y[0] : -1, done_cyc);
    end
  endtask

  task automatic test_start_held();
    int waited = 0;
    randomize_maps();
    build_expected();
    collect(1'b1, 0);
    tests_run++;
    if (obs_x.size() != 12 || done_cyc != 13) begin
      tests_failed++;
      $display("FAIL held_first: %0d writes done %0d, want 12 and 13", obs_x.size(), done_cyc);
    end
    @(posedge clock); #1;
    tests_run++;
    if (vga_plot !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL held_restart: plot=%b busy=%b, want 0 1", vga_plot, busy);
    end
    @(posedge clock); #1;
    tests_run++;
    if (vga_plot !== 1'b1 || vga_x !== 8'd0 || vga_y !== 8'd0 || int'(vga_colour) != exp_c[0]) begin
      tests_failed++;
      $display("FAIL held_second: plot=%b (%0d,%0d) col %0d, want 1 (0,0) col %0d", vga_plot, vga_x, vga_y, vga_colour, exp_c[0]);
    end
    start = 1'b0;
    while (done !== 1'b1 && waited < 40) begin
      @(posedge clock); #1;
      waited++;
    end
    tests_run++;
    if (waited >= 40) begin
      tests_failed++;
      $display("FAIL held_finish: done=%b after %0d cycles, want 1", done, waited);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_single_pixel();
    for (int e = 0; e < 2; e++) begin
      logic [5:0] want;
      glyph_colour1 = 6'($urandom_range(0, 63));
      glyph_enable1 = 1'(e);
      want = e ? glyph_colour1 : 6'b101010;
      start1 = 1'b1;
      @(posedge clock); #1;
      start1 = 1'b0;
      tests_run++;
      if (vga_plot1 !== 1'b0 || busy1 !== 1'b1) begin
        tests_failed++;
        $display("FAIL one_start[%0d]: plot=%b busy=%b, want 0 1", e, vga_plot1, busy1);
      end
      @(posedge clock); #1;
      tests_run++;
      if (vga_plot1 !== 1'b1 || vga_x1 !== 8'd0 || vga_y1 !== 8'd0 || vga_colour1 !== want) begin
        tests_failed++;
        $display("FAIL one_plot[%0d]: plot=%b (%0d,%0d) col %h, want 1 (0,0) col %h", e, vga_plot1, vga_x1, vga_y1, vga_colour1, want);
      end
      @(posedge clock); #1;
      tests_run++;
      if (done1 !== 1'b1 || vga_plot1 !== 1'b0 || busy1 !== 1'b0) begin
        tests_failed++;
        $display("FAIL one_done[%0d]: done=%b plot=%b busy=%b, want 1 0 0", e, done1, vga_plot1, busy1);
      end
      @(posedge clock); #1;
      tests_run++;
      if (done1 !== 1'b0) begin
        tests_failed++;
        $display("FAIL one_done_clear[%0d]: done=%b, want 0", e, done1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_plain_frame();
    test_glyph();
    test_pause();
    test_reset_mid_scan();
    test_start_held();
    test_single_pixel();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
